// File: rtl/key_scan_pkg.sv
// Shared types, sizes and helpers for the 4x4 matrix keypad scanner.
package key_scan_pkg;

    localparam int unsigned NROW   = 4;
    localparam int unsigned NCOL   = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CODE_W = 2 * IDX_W;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [IDX_W-1:0] lsb_idx(input logic [NCOL-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NCOL) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce_cnt.sv
// Saturating match counter shared by the press and release debounce paths.
// clr has priority over the stored count; clr together with inc loads 1.
module key_debounce_cnt
    import key_scan_pkg::*;
#(
    parameter int unsigned CNT_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done_c
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] base_c;

    // Effective starting count and "this update reaches the target" flag
    always_comb begin
        base_c = clr ? '0 : count;
        done_c = inc && ((32'(base_c) + 32'd1) >= CNT_MAX);
    end

    // Count register, saturating at CNT_MAX
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (32'(base_c) < CNT_MAX)) begin
            count <= base_c + CNT_W'(1);
        end else begin
            count <= base_c;
        end
    end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 matrix keypad scanner: rotates a one-hot row drive, debounces the
// column readback and reports accepted presses/releases plus a sticky irq.
module matrix_key_scan
    import key_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 3
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [NCOL-1:0]   col,
    input  logic              irq_clr,
    output logic [NROW-1:0]   row,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held,
    output logic              irq
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SLOT_W-1:0] slot_cnt;
    logic [NCOL-1:0]   col_meta;
    logic [NCOL-1:0]   col_sync;
    logic [NCOL-1:0]   cap_col;
    scan_state_e       state;
    scan_state_e       state_next;

    logic sample_c;
    logic col_any_c;
    logic col_match_c;
    logic cnt_clr_c;
    logic cnt_inc_c;
    logic cnt_done_c;
    logic accept_c;
    logic release_c;
    logic rotate_c;
    logic capture_c;

    // Two-flop synchroniser on the column readback
    always_ff @(posedge clk) begin
        if (RST) begin
            col_meta <= '0;
            col_sync <= '0;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // Free-running row slot timer; runs in every state
    always_ff @(posedge clk) begin
        if (RST || (slot_cnt == SLOT_W'(SCAN_DIV - 1))) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Sample strobe and column qualifiers
    always_comb begin
        sample_c    = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
        col_any_c   = |col_sync;
        col_match_c = (col_sync == cap_col);
    end

    // Match counter control: press matches in DEBOUNCE, zero samples in HELD
    always_comb begin
        cnt_clr_c = 1'b0;
        cnt_inc_c = 1'b0;
        case (state)
            SCAN: begin
                cnt_clr_c = 1'b1;
                cnt_inc_c = sample_c && col_any_c;
            end
            DEBOUNCE: begin
                if (sample_c) begin
                    cnt_inc_c = col_match_c;
                    cnt_clr_c = !col_match_c;
                end
            end
            HELD: begin
                // key_valid marks the first HELD cycle: start the release count fresh
                cnt_clr_c = key_valid;
                if (sample_c) begin
                    cnt_inc_c = !col_any_c;
                    cnt_clr_c = col_any_c;
                end
            end
            default: cnt_clr_c = 1'b1;
        endcase
    end

    key_debounce_cnt #(
        .CNT_MAX (DEBOUNCE_CNT)
    ) u_match_cnt (
        .clk    (clk),
        .rst    (RST),
        .clr    (cnt_clr_c),
        .inc    (cnt_inc_c),
        .done_c (cnt_done_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            SCAN: begin
                if (sample_c && col_any_c) begin
                    state_next = cnt_done_c ? HELD : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sample_c) begin
                    if (!col_match_c) begin
                        state_next = SCAN;
                    end else if (cnt_done_c) begin
                        state_next = HELD;
                    end
                end
            end
            HELD: begin
                if (sample_c && !col_any_c && cnt_done_c) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // FSM action strobes
    always_comb begin
        accept_c  = 1'b0;
        release_c = 1'b0;
        rotate_c  = 1'b0;
        capture_c = 1'b0;
        case (state)
            SCAN: begin
                rotate_c  = sample_c && !col_any_c;
                capture_c = sample_c && col_any_c;
                accept_c  = sample_c && col_any_c && cnt_done_c;
            end
            DEBOUNCE: begin
                rotate_c = sample_c && !col_match_c;
                accept_c = sample_c && col_match_c && cnt_done_c;
            end
            HELD: begin
                release_c = sample_c && !col_any_c && cnt_done_c;
            end
            default: ;
        endcase
    end

    // Row drive, captured column, key code and status outputs
    always_ff @(posedge clk) begin
        if (RST) begin
            row         <= NROW'(1);
            cap_col     <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
            irq         <= 1'b0;
        end else begin
            key_valid   <= accept_c;
            key_release <= release_c;
            if (rotate_c) begin
                row <= {row[NROW-2:0], row[NROW-1]};
            end
            if (capture_c) begin
                cap_col <= col_sync;
            end
            // Row is frozen from capture to accept, so the live row index is the captured one
            if (accept_c) begin
                key_code <= {lsb_idx(row), lsb_idx(col_sync)};
                key_held <= 1'b1;
            end else if (release_c) begin
                key_held <= 1'b0;
            end
            if (accept_c) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Scoreboard bench for matrix_key_scan: a behavioural keypad/scan model
// predicts press/release events and the visible status every cycle.
module tb_matrix_key_scan;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 3;

    logic       clk     = 1'b0;
    logic       RST     = 1'b1;
    logic [3:0] col     = 4'b0001;
    logic       irq_clr = 1'b0;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_held;
    logic       irq;

    matrix_key_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .col         (col),
        .irq_clr     (irq_clr),
        .row         (row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_held    (key_held),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state (keypad scanner described in terms of slots and samples)
    int unsigned mcyc      = 0;
    int unsigned since_rst = 0;
    logic [3:0]  m_s1 = '0, m_s2 = '0, m_cap = '0;
    int          m_slot = 0, m_ridx = 0, m_mode = 0, m_mcnt = 0, m_rcnt = 0, m_code = 0;
    bit          m_held = 0, m_irq = 0;

    typedef struct {
        bit          rel;
        int          code;
        int unsigned cyc;
    } ev_t;
    ev_t exp_q[$];

    int valid_cnt = 0;
    int rel_cnt   = 0;

    // Stimulus controls
    logic [3:0] press_map [4];
    logic [3:0] raw_col     = 4'b0001;
    bit         raw_mode    = 1;
    bit         bounce_mode = 0;
    bit         noise_mode  = 0;
    bit         hold_rst    = 1;
    bit         pulse_rst   = 0;
    bit         pulse_clr   = 0;
    bit         rand_clr    = 0;
    bit         rand_rst    = 0;
    bit         auto_clr    = 0;
    int         contention  = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, mcyc);
        end
    endtask

    function automatic int low_bit(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Will the coming edge accept a press (used to collide irq_clr with acceptance)
    function automatic bit accept_next();
        if (m_slot != int'(SCAN_DIV) - 1) return 0;
        if (m_mode == 0) return (m_s2 != 4'd0) && (DEBOUNCE_CNT == 1);
        if (m_mode == 1) return (m_s2 == m_cap) && (m_mcnt + 1 >= int'(DEBOUNCE_CNT));
        return 0;
    endfunction

    // Behavioural model: mode 0 scanning, 1 confirming a press, 2 key held
    always @(posedge clk) begin : ref_model
        logic [3:0] c;
        bit acc;
        bit rls;
        mcyc++;
        acc = 0;
        rls = 0;
        if (RST) begin
            m_s1 = '0; m_s2 = '0; m_cap = '0;
            m_slot = 0; m_ridx = 0; m_mode = 0; m_mcnt = 0; m_rcnt = 0; m_code = 0;
            m_held = 0; m_irq = 0; since_rst = 0;
        end else begin
            c = m_s2;
            if (m_slot == int'(SCAN_DIV) - 1) begin
                if (m_mode == 0) begin
                    if (c == 4'd0) begin
                        m_ridx = (m_ridx + 1) % 4;
                    end else begin
                        m_cap  = c;
                        m_mcnt = 1;
                        m_mode = 1;
                        if (m_mcnt >= int'(DEBOUNCE_CNT)) acc = 1;
                    end
                end else if (m_mode == 1) begin
                    if (c == m_cap) begin
                        m_mcnt++;
                        if (m_mcnt >= int'(DEBOUNCE_CNT)) acc = 1;
                    end else begin
                        m_mode = 0;
                        m_ridx = (m_ridx + 1) % 4;
                    end
                end else begin
                    if (c == 4'd0) begin
                        m_rcnt++;
                        if (m_rcnt >= int'(DEBOUNCE_CNT)) rls = 1;
                    end else begin
                        m_rcnt = 0;
                    end
                end
            end
            if (acc) begin
                m_code = m_ridx * 4 + low_bit(c);
                m_held = 1;
                m_irq  = 1;
                m_mode = 2;
                m_rcnt = 0;
                exp_q.push_back('{rel: 1'b0, code: m_code, cyc: mcyc});
            end else if (irq_clr) begin
                m_irq = 0;
            end
            if (rls) begin
                m_held = 0;
                m_mode = 0;
                exp_q.push_back('{rel: 1'b1, code: m_code, cyc: mcyc});
            end
            m_slot = (m_slot + 1) % int'(SCAN_DIV);
            m_s2 = m_s1;
            m_s1 = col;
            since_rst++;
        end
    end

    // Monitor: pops expected events when the DUT pulses, checks status each cycle
    always begin : monitor
        ev_t ev;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc < mcyc) begin
            checks++;
            failures++;
            $display("FAIL ev_missing: got no pulse, expected %s code %0d at cycle %0d",
                     exp_q[0].rel ? "release" : "press", exp_q[0].code, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (key_valid) valid_cnt++;
        if (key_release) rel_cnt++;
        if (key_valid || key_release) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ev_unexpected: got valid=%0b release=%0b, expected no pulse (cycle %0d)",
                         key_valid, key_release, mcyc);
            end else begin
                ev = exp_q.pop_front();
                chk("ev_kind", int'({key_release, key_valid}), ev.rel ? 2 : 1);
                chk("ev_code", int'(key_code), ev.code);
                chk("ev_cycle", int'(mcyc), int'(ev.cyc));
            end
        end
        chk("row", int'(row), 1 << m_ridx);
        chk("key_held", int'(key_held), int'(m_held));
        chk("irq", int'(irq), int'(m_irq));
        chk("key_code", int'(key_code), m_code);
    end

    // Advance n cycles, driving inputs just after each falling edge
    task automatic step(input int n);
        bit clr_now;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bounce_mode && m_slot == 0) raw_col = (raw_col == 4'd0) ? 4'b0001 : 4'b0000;
            if (noise_mode) raw_col = 4'($urandom_range(0, 15));
            col = raw_mode ? raw_col : press_map[m_ridx];
            clr_now = pulse_clr || (rand_clr && $urandom_range(0, 19) == 0);
            if (auto_clr && accept_next()) begin
                clr_now = 1;
                contention++;
            end
            irq_clr   = clr_now;
            pulse_clr = 0;
            RST       = hold_rst || pulse_rst || (rand_rst && $urandom_range(0, 999) == 0);
            pulse_rst = 0;
        end
    endtask

    task automatic wait_for(input bit want_release, input int max, output bit seen);
        seen = 0;
        for (int k = 0; k < max && !seen; k++) begin
            step(1);
            if (want_release ? key_release : key_valid) seen = 1;
        end
    endtask

    task automatic clear_map();
        for (int r = 0; r < 4; r++) press_map[r] = 4'd0;
    endtask

    initial begin : stimulus
        bit seen;
        int v0;
        int r0;
        int len;
        int kind;
        clear_map();

        // Reset held with a column asserted: no rotation, all outputs idle
        step(10);
        chk("rst_row", int'(row), 1);
        chk("rst_code", int'(key_code), 0);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_release", int'(key_release), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_irq", int'(irq), 0);

        // Press on row 0 stable from cycle 0: key_valid in cycle 12
        hold_rst = 0;
        wait_for(0, 40, seen);
        chk("p0_seen", int'(seen), 1);
        chk("p0_cycle", int'(since_rst), 12);
        chk("p0_code", int'(key_code), 0);
        chk("p0_irq", int'(irq), 1);
        chk("p0_held", int'(key_held), 1);
        chk("p0_row", int'(row), 1);

        raw_col = 4'd0;
        wait_for(1, 40, seen);
        chk("p0_rel_seen", int'(seen), 1);
        chk("p0_rel_held", int'(key_held), 0);

        // Idle rotation, no presses
        raw_mode = 0;
        v0 = valid_cnt;
        step(40);
        chk("idle_no_valid", valid_cnt - v0, 0);

        // Key at row 1 / column 2 -> code 6, then release exactly once
        press_map[1] = 4'b0100;
        wait_for(0, 100, seen);
        chk("p6_seen", int'(seen), 1);
        chk("p6_code", int'(key_code), 6);
        chk("p6_row", int'(row), 2);
        press_map[1] = 4'd0;
        r0 = rel_cnt;
        wait_for(1, 100, seen);
        chk("p6_rel_seen", int'(seen), 1);
        chk("p6_rel_held", int'(key_held), 0);
        chk("p6_rel_code", int'(key_code), 6);
        step(40);
        chk("p6_rel_once", rel_cnt - r0, 1);

        // Lone clear drops irq
        pulse_clr = 1;
        step(2);
        chk("clr_irq", int'(irq), 0);

        // Bounce on alternate samples never reaches acceptance
        raw_mode    = 1;
        raw_col     = 4'd0;
        bounce_mode = 1;
        v0 = valid_cnt;
        step(64);
        chk("bounce_no_valid", valid_cnt - v0, 0);
        chk("bounce_irq", int'(irq), 0);
        bounce_mode = 0;
        raw_col     = 4'd0;
        raw_mode    = 0;
        step(8);

        // irq_clr colliding with acceptance: set wins
        auto_clr = 1;
        press_map[2] = 4'b0010;
        wait_for(0, 100, seen);
        auto_clr = 0;
        chk("coll_seen", int'(seen), 1);
        chk("coll_code", int'(key_code), 9);
        chk("coll_irq", int'(irq), 1);
        chk("coll_hit", int'(contention > 0), 1);
        press_map[2] = 4'd0;
        wait_for(1, 100, seen);
        chk("coll_rel_seen", int'(seen), 1);
        pulse_clr = 1;
        step(2);
        chk("coll_clr_irq", int'(irq), 0);

        // Reset while held: everything back to reset values, no release pulse
        press_map[3] = 4'b1000;
        wait_for(0, 100, seen);
        chk("p15_seen", int'(seen), 1);
        chk("p15_code", int'(key_code), 15);
        step(6);
        r0 = rel_cnt;
        press_map[3] = 4'd0;
        pulse_rst = 1;
        step(2);
        chk("hrst_held", int'(key_held), 0);
        chk("hrst_row", int'(row), 1);
        chk("hrst_code", int'(key_code), 0);
        chk("hrst_irq", int'(irq), 0);
        step(40);
        chk("hrst_no_release", rel_cnt - r0, 0);

        // Randomised keypad activity, noise, clears and occasional resets
        rand_clr = 1;
        rand_rst = 1;
        v0 = valid_cnt;
        for (int seg = 0; seg < 120; seg++) begin
            len  = int'($urandom_range(1, 50));
            kind = int'($urandom_range(0, 9));
            clear_map();
            raw_mode   = 0;
            noise_mode = 0;
            if (kind >= 4 && kind < 8) begin
                press_map[$urandom_range(0, 3)] = 4'(1 << $urandom_range(0, 3));
            end else if (kind == 8) begin
                press_map[$urandom_range(0, 3)] = 4'($urandom_range(1, 15));
            end else if (kind == 9) begin
                raw_mode   = 1;
                noise_mode = 1;
            end
            step(len);
        end
        rand_clr   = 0;
        rand_rst   = 0;
        raw_mode   = 0;
        noise_mode = 0;
        clear_map();
        step(60);
        chk("rand_activity", int'(valid_cnt - v0 > 5), 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
